alu_issue_controller: RTL

- Instruction-side driver for the 16-bit ALU top. It accepts 16-bit instructions over a valid/ready handshake and holds a 4x16 register file.
- For each ALU instruction it drives operand A, operand B and the 3-bit opcode into the ALU. It writes the combinational accumulator back to the register file, then samples the ALU's registered carry and zero flags one cycle later.
- Sits between an instruction source (test sequencer or ROM walker) and the ALU top.

---
 rtl/alu_issue_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_controller.sv
// ============================================================================
// alu_issue_controller : valid/ready instruction driver for the 16-bit ALU top
//   Holds a 4x16 register file and sequences ALU operations and LDI writes.
//   Optional macro ALU_COND_EXEC_EN enables conditional ALU execution.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_controller #(
  parameter int NREGS = 4,
  parameter int WIDTH = 16
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iInstrValid,
  output logic             oInstrReady,
  input  logic [15:0]      iInstr,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic [2:0]       oAluOpcode,
  input  logic [WIDTH-1:0] iAluAccumulator,
  input  logic             iAluCarry,
  input  logic             iAluZero,
  output logic             oDoneValid,
  output logic [WIDTH-1:0] oResult,
  output logic             oCarry,
  output logic             oZero,
`ifdef ALU_COND_EXEC_EN
  output logic             oSkipped,
`endif
  input  logic [1:0]       iDbgSel,
  output logic [WIDTH-1:0] oDbgData
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_FLAGS = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             is_ldi_q, is_ldi_d;
  logic [1:0]       rd_q, rd_d;
  logic [9:0]       imm_q, imm_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             skipped_q, skipped_d;
  logic             cond_pass;
  logic [WIDTH-1:0] imm_ext;

  assign imm_ext = {{(WIDTH-10){1'b0}}, imm_q};

`ifdef ALU_COND_EXEC_EN
  always_comb begin
    cond_pass = 1'b1;
    case (iInstr[5:4])
      2'b00:   cond_pass = 1'b1;
      2'b01:   cond_pass = zero_q;
      2'b10:   cond_pass = carry_q;
      default: cond_pass = ~zero_q;
    endcase
  end
  logic unused_rsvd;
  assign unused_rsvd = ^iInstr[3:0];
`else
  assign cond_pass = 1'b1;
  logic unused_rsvd;
  assign unused_rsvd = ^iInstr[5:0];
`endif

  // State and datapath registers
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      is_ldi_q  <= 1'b0;
      rd_q      <= 2'd0;
      imm_q     <= 10'd0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= 3'd0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_ldi_q  <= is_ldi_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      skipped_q <= skipped_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iInstrValid) begin
          if (iInstr[12] || cond_pass) state_d = S_ISSUE;
          else                         state_d = S_DONE;
        end
      end
      S_ISSUE: state_d = is_ldi_q ? S_DONE : S_FLAGS;
      S_FLAGS: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; operands are captured at accept so aliasing reads old data
  always_comb begin
    is_ldi_d  = is_ldi_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    skipped_d = skipped_q;
    case (state_q)
      S_IDLE: begin
        if (iInstrValid) begin
          is_ldi_d  = iInstr[12];
          rd_d      = iInstr[11:10];
          imm_d     = iInstr[9:0];
          skipped_d = ~iInstr[12] & ~cond_pass;
          if (!iInstr[12] && cond_pass) begin
            alu_a_d  = regs_q[iInstr[9:8]];
            alu_b_d  = regs_q[iInstr[7:6]];
            alu_op_d = iInstr[15:13];
          end
        end
      end
      S_ISSUE: begin
        if (is_ldi_q) begin
          regs_d[rd_q] = imm_ext;
          result_d     = imm_ext;
        end else begin
          regs_d[rd_q] = iAluAccumulator;
          result_d     = iAluAccumulator;
        end
      end
      S_FLAGS: begin
        carry_d = iAluCarry;
        zero_d  = iAluZero;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    oInstrReady = (state_q == S_IDLE);
    oDoneValid  = (state_q == S_DONE);
    oAluA       = alu_a_q;
    oAluB       = alu_b_q;
    oAluOpcode  = alu_op_q;
    oResult     = result_q;
    oCarry      = carry_q;
    oZero       = zero_q;
    oDbgData    = regs_q[iDbgSel];
  end

`ifdef ALU_COND_EXEC_EN
  assign oSkipped = (state_q == S_DONE) & skipped_q;
`else
  logic unused_skip;
  assign unused_skip = skipped_q;
`endif

endmodule

`default_nettype wire
